instruction_fetch_unit: RTL and testbench

//  Fetch-side reader of the instruction ROM: owns the program counter, drives the ROM address and registers returned words.

---
 rtl/instruction_fetch_unit_pkg.sv | 20 ++
 rtl/instruction_fetch_unit_if.sv | 26 ++
 rtl/instruction_fetch_unit_nop_delay_counter.sv | 38 +++
 rtl/instruction_fetch_unit.sv | 103 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch definitions: opcode encodings, instruction field layout and FSM states.
// Every fetch-side file takes opcodes and field positions from here rather than using literals.
package instruction_fetch_unit_pkg;

    localparam int OPC_W     = 4;
    localparam int PAYLOAD_W = 24;

    localparam logic [OPC_W-1:0] OPC_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OPC_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OPC_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OPC_LD  = 4'h3;
    localparam logic [OPC_W-1:0] OPC_ST  = 4'h4;
    localparam logic [OPC_W-1:0] OPC_BR  = 4'h5;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_DELAY = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch bus: the ROM address/data pair, the decode handshake and the branch redirect.
// The master modport is the fetch unit; the slave modport is the ROM/decode/execute side.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 28
) ();
    logic [ADDR_W-1:0]  oAddress;
    logic [INSTR_W-1:0] iInstruction;
    logic [INSTR_W-1:0] oInstruction;
    logic [ADDR_W-1:0]  oInstrAddress;
    logic               oValid;
    logic               iReady;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic               oBusy;

    modport master (
        output oAddress, oInstruction, oInstrAddress, oValid, oBusy,
        input  iInstruction, iReady, iBranchTaken, iBranchTarget
    );

    modport slave (
        input  oAddress, oInstruction, oInstrAddress, oValid, oBusy,
        output iInstruction, iReady, iBranchTaken, iBranchTarget
    );
endinterface

// File: rtl/instruction_fetch_unit_nop_delay_counter.sv
// NOP stall counter: loads the NOP payload, counts down one per cycle, flags 1 and 0.
// Clear beats load beats decrement; decrementing at zero holds zero.
module nop_delay_counter #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         last_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == W'(1));
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: PC, registered ROM word to decode (1-cycle latency, 1/cycle throughput), branch flush.
// Holds everything while oValid && !iReady. Optional NOP_DELAY_EN turns `NOP N` into an N-cycle stall.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'd0,
    parameter int          ADDR_W     = 16,
    parameter int          INSTR_W    = 28
) (
    input logic                     Clock,
    input logic                     Reset,
    instruction_fetch_unit_if.master bus
);
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  iaddr_q, iaddr_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               vld_q, vld_d;
    fetch_state_e       state_q, state_d;
    logic               load;

    assign load = (state_q == ST_FETCH) && (!vld_q || bus.iReady);

`ifdef NOP_DELAY_EN
    logic                 is_nop;
    logic [PAYLOAD_W-1:0] nop_n;
    logic                 cnt_last, cnt_zero;

    assign is_nop = (bus.iInstruction[INSTR_W-1 -: OPC_W] == OPC_NOP);
    assign nop_n  = bus.iInstruction[PAYLOAD_W-1:0];

    nop_delay_counter #(.W(PAYLOAD_W)) u_delay (
        .clk        (Clock),
        .rst_n      (Reset),
        .clr_i      (bus.iBranchTaken),
        .load_i     (!bus.iBranchTaken && load && is_nop && (nop_n != '0)),
        .load_val_i (nop_n),
        .dec_i      (!bus.iBranchTaken && (state_q == ST_DELAY)),
        .last_o     (cnt_last),
        .zero_o     (cnt_zero)
    );
`endif

    always_comb begin
        pc_d    = pc_q;
        iaddr_d = iaddr_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        state_d = state_q;
        if (bus.iBranchTaken) begin
            // Flush: a word accepted this same cycle is consumed, nothing new is loaded.
            pc_d    = bus.iBranchTarget;
            vld_d   = 1'b0;
            state_d = ST_FETCH;
        end else if (load) begin
            pc_d = pc_q + ADDR_W'(1);
`ifdef NOP_DELAY_EN
            if (is_nop) begin
                vld_d = 1'b0;
                if (nop_n != '0) begin
                    state_d = ST_DELAY;
                end
            end else begin
`else
            begin
`endif
                instr_d = bus.iInstruction;
                iaddr_d = pc_q;
                vld_d   = 1'b1;
            end
        end
`ifdef NOP_DELAY_EN
        else if ((state_q == ST_DELAY) && (cnt_last || cnt_zero)) begin
            state_d = ST_FETCH;
        end
`endif
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            pc_q    <= ADDR_W'(RESET_ADDR);
            iaddr_q <= '0;
            instr_q <= '0;
            vld_q   <= 1'b0;
            state_q <= ST_FETCH;
        end else begin
            pc_q    <= pc_d;
            iaddr_q <= iaddr_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            state_q <= state_d;
        end
    end

    assign bus.oAddress      = pc_q;
    assign bus.oInstruction  = instr_q;
    assign bus.oInstrAddress = iaddr_q;
    assign bus.oValid        = vld_q;
`ifdef NOP_DELAY_EN
    assign bus.oBusy = (state_q == ST_DELAY);
`else
    assign bus.oBusy = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: streaming, stall, branch, wrap, reset, NOP handling.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        nop_en = 1'b0;
    logic [15:0] nop_addr = 16'd0;
    logic [23:0] nop_n = 24'd0;

    instruction_fetch_unit_if #(.ADDR_W(16), .INSTR_W(28)) bus ();

    instruction_fetch_unit #(.RESET_ADDR(16'd0), .ADDR_W(16), .INSTR_W(28)) dut (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model ROM: word k = {ADD, k}, with one optional NOP slot.
    assign bus.iInstruction = (nop_en && (bus.oAddress == nop_addr)) ? {OPC_NOP, nop_n}
                                                                      : {OPC_ADD, 8'h00, bus.oAddress};

    function automatic logic [27:0] add_w(input logic [15:0] k);
        return {OPC_ADD, 8'h00, k};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [15:0] k);
        chk({tag, ".vld"},   32'(bus.oValid), 32'd1);
        chk({tag, ".instr"}, 32'(bus.oInstruction), 32'(add_w(k)));
        chk({tag, ".iaddr"}, 32'(bus.oInstrAddress), 32'(k));
    endtask

    task automatic branch_to(input logic [15:0] tgt);
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = tgt;
        step();
        bus.iBranchTaken  = 1'b0;
        chk("br.flush", 32'(bus.oValid), 32'd0);
        chk("br.pc", 32'(bus.oAddress), 32'(tgt));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, ".vld"},   32'(bus.oValid), 32'd0);
        chk({tag, ".instr"}, 32'(bus.oInstruction), 32'd0);
        chk({tag, ".iaddr"}, 32'(bus.oInstrAddress), 32'd0);
        chk({tag, ".pc"},    32'(bus.oAddress), 32'd0);
        chk({tag, ".busy"},  32'(bus.oBusy), 32'd0);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.iReady        = 1'b1;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'd0;
        step();
        step();
        chk_reset_state("rst");

        // Streaming: word 0 one cycle after release, then one per cycle.
        rst_n = 1'b1;
        step();
        chk_word("s0", 16'd0);
        chk("s0.pc", 32'(bus.oAddress), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk_word($sformatf("s%0d", k), 16'(k));
        end

        // Stall three cycles: everything frozen.
        bus.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_word($sformatf("stall%0d", i), 16'd4);
            chk("stall.pc", 32'(bus.oAddress), 32'd5);
        end
        bus.iReady = 1'b1;
        step();
        chk_word("resume5", 16'd5);
        step();
        chk_word("resume6", 16'd6);

        // Branch with a concurrent handshake: word 6 consumed, target 2 cycles later.
        branch_to(16'd13);
        step();
        chk_word("tgt13", 16'd13);
        step();
        chk_word("tgt14", 16'd14);

        // PC wraparound.
        branch_to(16'hFFFE);
        step();
        chk_word("wrapFFFE", 16'hFFFE);
        step();
        chk_word("wrapFFFF", 16'hFFFF);
        step();
        chk_word("wrap0000", 16'h0000);
        chk("wrap.pc", 32'(bus.oAddress), 32'd1);

`ifdef NOP_DELAY_EN
        // NOP 4: exactly four busy cycles, then word 3.
        nop_en = 1'b1; nop_addr = 16'd2; nop_n = 24'd4;
        branch_to(16'd0);
        step(); chk_word("n4.w0", 16'd0);
        step(); chk_word("n4.w1", 16'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("n4.busy%0d", i), 32'(bus.oBusy), 32'd1);
            chk($sformatf("n4.vld%0d", i), 32'(bus.oValid), 32'd0);
        end
        step();
        chk("n4.busyend", 32'(bus.oBusy), 32'd0);
        chk("n4.vldend", 32'(bus.oValid), 32'd0);
        chk("n4.pc", 32'(bus.oAddress), 32'd3);
        step(); chk_word("n4.w3", 16'd3);

        // NOP 0: swallowed, single gap cycle.
        nop_n = 24'd0;
        branch_to(16'd0);
        step(); chk_word("n0.w0", 16'd0);
        step(); chk_word("n0.w1", 16'd1);
        step();
        chk("n0.gap", 32'(bus.oValid), 32'd0);
        chk("n0.busy", 32'(bus.oBusy), 32'd0);
        step(); chk_word("n0.w3", 16'd3);

        // Branch during the second DELAY cycle of a long NOP.
        nop_n = 24'd4000;
        branch_to(16'd0);
        step(); chk_word("ab.w0", 16'd0);
        step(); chk_word("ab.w1", 16'd1);
        step(); chk("ab.busy1", 32'(bus.oBusy), 32'd1);
        step(); chk("ab.busy2", 32'(bus.oBusy), 32'd1);
        branch_to(16'd20);
        chk("ab.busyoff", 32'(bus.oBusy), 32'd0);
        step(); chk_word("ab.w20", 16'd20);
        chk("ab.busy20", 32'(bus.oBusy), 32'd0);
        step(); chk_word("ab.w21", 16'd21);
        chk("ab.busy21", 32'(bus.oBusy), 32'd0);
        nop_en = 1'b0;
`else
        // Without the delay feature a NOP is an ordinary instruction.
        nop_en = 1'b1; nop_addr = 16'd2; nop_n = 24'd5;
        branch_to(16'd0);
        step(); chk_word("nf.w0", 16'd0);
        step(); chk_word("nf.w1", 16'd1);
        step();
        chk("nf.vld", 32'(bus.oValid), 32'd1);
        chk("nf.instr", 32'(bus.oInstruction), 32'({OPC_NOP, 24'd5}));
        chk("nf.busy", 32'(bus.oBusy), 32'd0);
        step(); chk_word("nf.w3", 16'd3);
        nop_en = 1'b0;
`endif

        // Reset mid-stream dominates a simultaneous branch.
        step(); step();
        rst_n = 1'b0;
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'd77;
        step();
        bus.iBranchTaken = 1'b0;
        chk_reset_state("midrst");
        rst_n = 1'b1;
        step();
        chk_word("post.w0", 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
